// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - lookup/update bus of the branch target buffer
interface btb_predictor_if #(
   parameter int IW = 3
);
   logic [31:0]   lookup_pc;
   logic          predict;
   logic          hit;
   logic [31:0]   target;
   logic [IW-1:0] lookup_idx;
   logic          upd_en;
   logic [31:0]   upd_pc;
   logic [IW-1:0] upd_idx;
   logic          upd_taken;
   logic [31:0]   upd_target;
   logic          upd_mispredict;
   logic          flush;
   logic [15:0]   mispredict_cnt;

   modport master (
      output lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
             upd_mispredict, flush,
      input  predict, hit, target, lookup_idx, mispredict_cnt
   );

   modport slave (
      input  lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
             upd_mispredict, flush,
      output predict, hit, target, lookup_idx, mispredict_cnt
   );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with saturating direction counters
// Define BTB_GHR_EN to index the counters gshare-style with a global history register.
module btb_predictor #(
   parameter int ENTRIES = 8,
   parameter int CTR_W   = 2,
   parameter int HIST_W  = 3
) (
   input logic           CLK,
   input logic           RST,
   btb_predictor_if.slave bus
);
   localparam int IW = $clog2(ENTRIES);
   localparam int TW = 30 - IW;
   localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
   localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

   if (ENTRIES < 2 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0 ||
       CTR_W < 1 || CTR_W > 4 || HIST_W < 1 || HIST_W > IW) begin : g_bad_params
      $error("btb_predictor: illegal ENTRIES/CTR_W/HIST_W");
   end

   logic [ENTRIES-1:0] valid;
   logic [TW-1:0]      tag_mem [ENTRIES];
   logic [31:0]        tgt_mem [ENTRIES];
   logic [CTR_W-1:0]   ctr     [ENTRIES];
   logic [15:0]        mis_cnt;

   logic [IW-1:0] look_bi;
   logic [TW-1:0] look_tag;
   logic [IW-1:0] look_idx;
   logic          look_hit;
   logic [IW-1:0] upd_bi;
   logic [TW-1:0] upd_tag;
   logic          upd_hit;
   logic          unused_upd_pc_lsbs;

   assign look_bi  = bus.lookup_pc[IW+1:2];
   assign look_tag = bus.lookup_pc[31:IW+2];
   assign look_hit = valid[look_bi] && (tag_mem[look_bi] == look_tag);

   assign upd_bi   = bus.upd_pc[IW+1:2];
   assign upd_tag  = bus.upd_pc[31:IW+2];
   assign upd_hit  = valid[upd_bi] && (tag_mem[upd_bi] == upd_tag);
   assign unused_upd_pc_lsbs = ^bus.upd_pc[1:0];

`ifdef BTB_GHR_EN
   logic [HIST_W-1:0] ghr;

   assign look_idx = look_bi ^ IW'(ghr);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ghr <= '0;
      end else if (bus.flush) begin
         ghr <= '0;
      end else if (bus.upd_en) begin
         // newest outcome enters at the LSB, oldest falls off the top
         ghr <= HIST_W'({ghr, bus.upd_taken});
      end
   end
`else
   assign look_idx = look_bi;
`endif

   assign bus.hit            = look_hit;
   assign bus.lookup_idx     = look_idx;
   assign bus.predict        = look_hit && ctr[look_idx][CTR_W-1];
   assign bus.target         = look_hit ? tgt_mem[look_bi] : bus.lookup_pc + 32'd4;
   assign bus.mispredict_cnt = mis_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid   <= '0;
         mis_cnt <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= CTR_WEAK_NT;
         end
      end else begin
         if (bus.flush) begin
            valid <= '0;
         end else if (bus.upd_en) begin
            if (upd_hit) begin
               if (bus.upd_taken) begin
                  if (ctr[bus.upd_idx] != CTR_MAX) begin
                     ctr[bus.upd_idx] <= ctr[bus.upd_idx] + 1'b1;
                  end
               end else if (ctr[bus.upd_idx] != '0) begin
                  ctr[bus.upd_idx] <= ctr[bus.upd_idx] - 1'b1;
               end
            end else if (bus.upd_taken) begin
               valid[upd_bi]    <= 1'b1;
               ctr[bus.upd_idx] <= CTR_WEAK_T;
            end
         end
         // the miss counter tracks pipeline events and is not affected by flush
         if (bus.upd_en && bus.upd_mispredict && mis_cnt != 16'hFFFF) begin
            mis_cnt <= mis_cnt + 16'd1;
         end
      end
   end

   // tag/target arrays carry no reset; valid gates their use
   always_ff @(posedge CLK) begin
      if (!RST && !bus.flush && bus.upd_en && bus.upd_taken) begin
         tag_mem[upd_bi] <= upd_tag;
         tgt_mem[upd_bi] <= bus.upd_target;
      end
   end
endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - random and directed checks of btb_predictor against a table model
`timescale 1ns/1ps
module tb_btb_predictor;
   localparam int ENTRIES = 8;
   localparam int CTR_W   = 2;
   localparam int HIST_W  = 3;
   localparam int IW      = 3;
   localparam int CMAX    = (1 << CTR_W) - 1;
   localparam int CHALF   = 1 << (CTR_W - 1);

   logic CLK = 1'b0;
   logic RST = 1'b0;
   bit   chk_on = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   btb_predictor_if #(.IW(IW)) bus ();

   btb_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .HIST_W(HIST_W)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   // model: the table contents as the rules describe them
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int          m_cnt;
   int unsigned m_ghr;

   function automatic int unsigned f_bi(input logic [31:0] pc);
      return (pc >> 2) % ENTRIES;
   endfunction

   function automatic int unsigned f_tag(input logic [31:0] pc);
      return pc >> (IW + 2);
   endfunction

   function automatic int unsigned f_lidx(input logic [31:0] pc);
`ifdef BTB_GHR_EN
      return f_bi(pc) ^ m_ghr;
`else
      return f_bi(pc);
`endif
   endfunction

   function automatic bit f_known(input logic [31:0] pc);
      return m_valid[f_bi(pc)] && (m_tag[f_bi(pc)] == f_tag(pc));
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] <= 1'b0;
            m_ctr[i]   <= CHALF - 1;
         end
         m_cnt <= 0;
         m_ghr <= 0;
      end else begin
         if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] <= 1'b0;
            m_ghr <= 0;
         end else if (bus.upd_en) begin
            if (f_known(bus.upd_pc)) begin
               if (bus.upd_taken) begin
                  m_ctr[bus.upd_idx] <= (m_ctr[bus.upd_idx] < CMAX) ? m_ctr[bus.upd_idx] + 1 : CMAX;
                  m_tgt[f_bi(bus.upd_pc)] <= bus.upd_target;
               end else begin
                  m_ctr[bus.upd_idx] <= (m_ctr[bus.upd_idx] > 0) ? m_ctr[bus.upd_idx] - 1 : 0;
               end
            end else if (bus.upd_taken) begin
               m_valid[f_bi(bus.upd_pc)] <= 1'b1;
               m_tag[f_bi(bus.upd_pc)]   <= f_tag(bus.upd_pc);
               m_tgt[f_bi(bus.upd_pc)]   <= bus.upd_target;
               m_ctr[bus.upd_idx]        <= CHALF;
            end
            m_ghr <= ((m_ghr << 1) | 32'(bus.upd_taken)) % (1 << HIST_W);
         end
         if (bus.upd_en && bus.upd_mispredict && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_on) begin
         logic [31:0] pc;
         bit          ehit;
         #2;
         pc   = bus.lookup_pc;
         ehit = f_known(pc);
         check("hit", 32'(bus.hit), 32'(ehit));
         check("predict", 32'(bus.predict), 32'(ehit && m_ctr[f_lidx(pc)] >= CHALF));
         check("target", bus.target, ehit ? m_tgt[f_bi(pc)] : pc + 32'd4);
         check("lookup_idx", 32'(bus.lookup_idx), f_lidx(pc));
         check("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_cnt));
      end
   end

   task automatic cyc(input logic [31:0] lpc, input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic um, input logic fl);
      @(negedge CLK);
      bus.lookup_pc      = lpc;
      bus.upd_en         = ue;
      bus.upd_pc         = upc;
      bus.upd_idx        = IW'(f_lidx(upc));
      bus.upd_taken      = ut;
      bus.upd_target     = utg;
      bus.upd_mispredict = um;
      bus.flush          = fl;
   endtask

   task automatic look(input logic [31:0] lpc);
      cyc(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #3;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      if ($urandom_range(0, 15) == 0) return $urandom;
      p = (32'($urandom_range(0, 3)) << (IW + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
      return p;
   endfunction

   initial begin
      bus.lookup_pc = '0; bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_idx = '0;
      bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.flush = 1'b0;
      #1 RST = 1'b1;
      chk_on = 1'b1;

      look(32'h40);
      check("rst_hit", 32'(bus.hit), 32'd0);
      check("rst_predict", 32'(bus.predict), 32'd0);
      check("rst_target", bus.target, 32'h44);
      check("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
      cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      RST = 1'b0;
      #3;
      check("post_rst_target", bus.target, 32'h44);

`ifndef BTB_GHR_EN
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      look(32'h40);
      check("alloc_hit", 32'(bus.hit), 32'd1);
      check("alloc_predict", 32'(bus.predict), 32'd1);
      check("alloc_target", bus.target, 32'h100);
      repeat (4) cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      look(32'h40);
      check("sat_hi_predict", 32'(bus.predict), 32'd1);
      repeat (3) cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
      look(32'h40);
      check("sat_lo_hit", 32'(bus.hit), 32'd1);
      check("sat_lo_predict", 32'(bus.predict), 32'd0);
      check("three_mispredicts", 32'(bus.mispredict_cnt), 32'd3);
      look(32'h60);
      check("alias_hit", 32'(bus.hit), 32'd0);
      check("alias_target", bus.target, 32'h64);
      cyc(32'h60, 1'b1, 32'h60, 1'b1, 32'h200, 1'b0, 1'b0);
      look(32'h40);
      check("evicted_hit", 32'(bus.hit), 32'd0);
      look(32'h60);
      check("replaced_target", bus.target, 32'h200);
      check("replaced_predict", 32'(bus.predict), 32'd1);
`endif

      cyc(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b1);
      look(32'h80);
      check("flush_upd_hit", 32'(bus.hit), 32'd0);
      look(32'h60);
      check("flush_60_hit", 32'(bus.hit), 32'd0);

      cyc(32'hA0, 1'b1, 32'hA0, 1'b1, 32'h400, 1'b1, 1'b0);
      look(32'hA0);
      check("pre_rst_hit", 32'(bus.hit), 32'd1);
      cyc(32'hC0, 1'b1, 32'hC0, 1'b1, 32'h500, 1'b1, 1'b0);
      #1 RST = 1'b1;
      cyc(32'hC0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      RST = 1'b0;
      #3;
      check("rst_discard_hit", 32'(bus.hit), 32'd0);
      check("rst_discard_cnt", 32'(bus.mispredict_cnt), 32'd0);

`ifdef BTB_GHR_EN
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h40);
      check("gshare_idx", 32'(bus.lookup_idx), 32'd6);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic fl;
         fl = ($urandom_range(0, 31) == 0);
         cyc(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
             $urandom, fl ? 1'b0 : 1'($urandom_range(0, 1)), fl);
      end

      repeat (65540) cyc(rand_pc(), 1'b1, rand_pc(), 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0);
      look(32'h40);
      check("cnt_saturated", 32'(bus.mispredict_cnt), 32'hFFFF);

      chk_on = 1'b0;
      #10;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
